// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, PC-select codes and counter width for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_REDIR = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_ALU    = 2'b10;
    localparam logic [1:0] PCSRC_RSVD   = 2'b11;

    localparam int CNT_W = 16;

    // The reserved code 11 deliberately falls through as sequential.
    function automatic logic is_redirect(input logic [1:0] src);
        return (src == PCSRC_TARGET) || (src == PCSRC_ALU);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with increment enable
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !(&cnt_q)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - dual-lane fetch control: stall, redirect, halt and perf counters
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             StallReq,
    input  logic             HaltReq,
    input  logic             ValidE1,
    input  logic             ValidE2,
    input  logic [1:0]       PCSrcE1,
    input  logic [1:0]       PCSrcE2,
    input  logic             SingleIssue,
    output logic             en1,
    output logic             en2,
    output logic [1:0]       PCSrcF1,
    output logic [1:0]       PCSrcF2,
    output logic             FlushD,
    output logic             FlushE,
    output logic             KillE2,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] RedirCnt
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         stall_inc;
    logic         redir_inc;
    logic         halt_ev;
    logic         redir1_ev;
    logic         redir2_ev;

    assign halt_ev   = HaltReq & ValidE1;
    assign redir1_ev = ValidE1 & is_redirect(PCSrcE1);
    assign redir2_ev = ValidE2 & is_redirect(PCSrcE2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        en1       = 1'b1;
        en2       = 1'b1;
        PCSrcF1   = PCSRC_SEQ;
        PCSrcF2   = PCSRC_SEQ;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        KillE2    = 1'b0;
        stall_inc = 1'b0;
        redir_inc = 1'b0;

        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (halt_ev) begin
                    en1     = 1'b0;
                    en2     = 1'b0;
                    KillE2  = 1'b1;
                    FlushD  = 1'b1;
                    state_d = ST_HALT;
                end else if (redir1_ev) begin
                    PCSrcF1   = PCSrcE1;
                    KillE2    = 1'b1;
                    FlushD    = 1'b1;
                    FlushE    = 1'b1;
                    redir_inc = 1'b1;
                    state_d   = ST_REDIR;
                end else if (redir2_ev) begin
                    PCSrcF2   = PCSrcE2;
                    FlushD    = 1'b1;
                    FlushE    = 1'b1;
                    redir_inc = 1'b1;
                    state_d   = ST_REDIR;
                end else if (StallReq) begin
                    en1       = 1'b0;
                    en2       = 1'b0;
                    stall_inc = 1'b1;
                    state_d   = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // Second bubble of a redirect: the wrong-path decode slot is squashed.
            ST_REDIR: begin
                FlushD  = 1'b1;
                state_d = ST_RUN;
            end
            ST_HALT: begin
                en1 = 1'b0;
                en2 = 1'b0;
            end
        endcase

        if (SingleIssue) begin
            en2 = 1'b0;
        end

        // Reset masks all events so fetch sees a clean sequential RUN.
        if (!rst) begin
            en1       = 1'b1;
            en2       = ~SingleIssue;
            PCSrcF1   = PCSRC_SEQ;
            PCSrcF2   = PCSRC_SEQ;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            KillE2    = 1'b0;
            stall_inc = 1'b0;
            redir_inc = 1'b0;
        end
    end

    assign State = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (stall_inc),
        .count_o (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (redir_inc),
        .count_o (RedirCnt)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        StallReq;
    logic        HaltReq;
    logic        ValidE1;
    logic        ValidE2;
    logic [1:0]  PCSrcE1;
    logic [1:0]  PCSrcE2;
    logic        SingleIssue;
    logic        en1;
    logic        en2;
    logic [1:0]  PCSrcF1;
    logic [1:0]  PCSrcF2;
    logic        FlushD;
    logic        FlushE;
    logic        KillE2;
    logic [1:0]  State;
    logic [15:0] StallCnt;
    logic [15:0] RedirCnt;

    int n_vec;
    int n_err;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .StallReq    (StallReq),
        .HaltReq     (HaltReq),
        .ValidE1     (ValidE1),
        .ValidE2     (ValidE2),
        .PCSrcE1     (PCSrcE1),
        .PCSrcE2     (PCSrcE2),
        .SingleIssue (SingleIssue),
        .en1         (en1),
        .en2         (en2),
        .PCSrcF1     (PCSrcF1),
        .PCSrcF2     (PCSrcF2),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .KillE2      (KillE2),
        .State       (State),
        .StallCnt    (StallCnt),
        .RedirCnt    (RedirCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {en1, en2, FlushD, FlushE, KillE2, PCSrcF1, PCSrcF2}
    function automatic logic [15:0] outs();
        return {7'd0, en1, en2, FlushD, FlushE, KillE2, PCSrcF1, PCSrcF2};
    endfunction

    function automatic logic [15:0] mk(input logic e1, input logic e2, input logic fd,
                                       input logic fe, input logic k,
                                       input logic [1:0] f1, input logic [1:0] f2);
        return {7'd0, e1, e2, fd, fe, k, f1, f2};
    endfunction

    task automatic idle();
        StallReq = 1'b0;
        HaltReq  = 1'b0;
        ValidE1  = 1'b0;
        ValidE2  = 1'b0;
        PCSrcE1  = 2'b00;
        PCSrcE2  = 2'b00;
    endtask

    task automatic step_state(input string tag, input logic [1:0] exp_state);
        @(posedge clk);
        #1;
        chk(tag, 16'(State), 16'(exp_state));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        SingleIssue = 1'b1;
        idle();
        ValidE1  = 1'b1;
        PCSrcE1  = 2'b01;
        StallReq = 1'b1;
        #2;
        chk("rst_outs_si", outs(), mk(1, 0, 0, 0, 0, 2'b00, 2'b00));
        chk("rst_state", 16'(State), 16'h0000);
        chk("rst_cnts", {StallCnt | RedirCnt}, 16'h0000);
        SingleIssue = 1'b0;
        #1;
        chk("rst_outs", outs(), mk(1, 1, 0, 0, 0, 2'b00, 2'b00));

        // Scenario 1: quiet run after reset
        @(negedge clk);
        idle();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("s1_state", 16'(State), 16'h0000);
        chk("s1_outs", outs(), mk(1, 1, 0, 0, 0, 2'b00, 2'b00));
        chk("s1_stallcnt", StallCnt, 16'd0);
        chk("s1_redircnt", RedirCnt, 16'd0);

        // Scenario 2: three stall cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            StallReq = 1'b1;
            #1;
            chk("s2_stall_outs", outs(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00));
            step_state("s2_state_stall", 2'b01);
        end
        chk("s2_stallcnt", StallCnt, 16'd3);
        @(negedge clk);
        StallReq = 1'b0;
        #1;
        chk("s2_release_outs", outs(), mk(1, 1, 0, 0, 0, 2'b00, 2'b00));
        step_state("s2_state_run", 2'b00);
        chk("s2_stallcnt_hold", StallCnt, 16'd3);

        // Scenario 3: lane-1 redirect beats lane-2 redirect
        @(negedge clk);
        ValidE1 = 1'b1;
        ValidE2 = 1'b1;
        PCSrcE1 = 2'b01;
        PCSrcE2 = 2'b10;
        #1;
        chk("s3_redir1_outs", outs(), mk(1, 1, 1, 1, 1, 2'b01, 2'b00));
        step_state("s3_state_redir", 2'b10);
        chk("s3_redircnt", RedirCnt, 16'd1);
        @(negedge clk);
        #1;
        chk("s3_redir_bubble", outs(), mk(1, 1, 1, 0, 0, 2'b00, 2'b00));
        step_state("s3_state_run", 2'b00);
        chk("s3_redircnt_hold", RedirCnt, 16'd1);

        // Scenario 4: lane-2 redirect overrides a stall request
        @(negedge clk);
        idle();
        StallReq = 1'b1;
        ValidE2  = 1'b1;
        PCSrcE2  = 2'b10;
        #1;
        chk("s4_redir2_outs", outs(), mk(1, 1, 1, 1, 0, 2'b00, 2'b10));
        step_state("s4_state_redir", 2'b10);
        chk("s4_stallcnt", StallCnt, 16'd3);
        chk("s4_redircnt", RedirCnt, 16'd2);
        @(negedge clk);
        #1;
        chk("s4_bubble_ignores_stall", outs(), mk(1, 1, 1, 0, 0, 2'b00, 2'b00));
        step_state("s4_state_run", 2'b00);
        chk("s4_stallcnt_hold", StallCnt, 16'd3);

        // Reserved PCSrc code never redirects
        @(negedge clk);
        idle();
        ValidE1 = 1'b1;
        ValidE2 = 1'b1;
        PCSrcE1 = 2'b11;
        PCSrcE2 = 2'b11;
        #1;
        chk("rsvd_outs", outs(), mk(1, 1, 0, 0, 0, 2'b00, 2'b00));
        step_state("rsvd_state", 2'b00);
        chk("rsvd_redircnt", RedirCnt, 16'd2);

        // Invalid lane-1 redirect is ignored
        @(negedge clk);
        idle();
        PCSrcE1 = 2'b01;
        #1;
        chk("inval_outs", outs(), mk(1, 1, 0, 0, 0, 2'b00, 2'b00));

        // Scenario 5: halt, sticky for 10 cycles, reset pulse recovers
        @(negedge clk);
        idle();
        HaltReq = 1'b1;
        ValidE1 = 1'b1;
        ValidE2 = 1'b1;
        PCSrcE2 = 2'b01;
        #1;
        chk("s5_halt_outs", outs(), mk(0, 0, 1, 0, 1, 2'b00, 2'b00));
        step_state("s5_state_halt", 2'b11);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle();
            StallReq = i[0];
            ValidE1  = 1'b1;
            PCSrcE1  = 2'b01;
            #1;
            chk("s5_halt_sticky_outs", outs(), mk(0, 0, 0, 0, 0, 2'b00, 2'b00));
            step_state("s5_halt_sticky_state", 2'b11);
        end
        chk("s5_redircnt", RedirCnt, 16'd2);
        chk("s5_stallcnt", StallCnt, 16'd3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("s5_async_state", 16'(State), 16'h0000);
        chk("s5_async_cnts", {StallCnt | RedirCnt}, 16'h0000);
        chk("s5_async_outs", outs(), mk(1, 1, 0, 0, 0, 2'b00, 2'b00));
        @(negedge clk);
        idle();
        rst = 1'b1;
        step_state("s5_resume_run", 2'b00);

        // Reset in the middle of a stall
        @(negedge clk);
        StallReq = 1'b1;
        step_state("midstall_state", 2'b01);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midstall_rst_state", 16'(State), 16'h0000);
        chk("midstall_rst_cnt", StallCnt, 16'd0);
        @(negedge clk);
        StallReq = 1'b0;
        rst = 1'b1;
        step_state("midstall_resume", 2'b00);

        // Scenario 6: saturation of RedirCnt, single issue throughout
        SingleIssue = 1'b1;
        @(negedge clk);
        force dut.u_redir_cnt.cnt_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.u_redir_cnt.cnt_q;
        #1;
        chk("s6_preload", RedirCnt, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle();
            ValidE1 = 1'b1;
            PCSrcE1 = 2'b10;
            #1;
            chk("s6_redir_outs_si", outs(), mk(1, 0, 1, 1, 1, 2'b10, 2'b00));
            step_state("s6_state_redir", 2'b10);
            chk("s6_redircnt_sat", RedirCnt, 16'hFFFF);
            @(negedge clk);
            idle();
            #1;
            chk("s6_bubble_si", outs(), mk(1, 0, 1, 0, 0, 2'b00, 2'b00));
            step_state("s6_state_run", 2'b00);
        end
        @(negedge clk);
        #1;
        chk("s6_run_en2", {en1, en2}, 16'b10);
        StallReq = 1'b1;
        step_state("s6_state_stall", 2'b01);
        @(negedge clk);
        StallReq = 1'b0;
        #1;
        chk("s6_stall_state_en2", {en1, en2}, 16'b10);
        step_state("s6_back_run", 2'b00);
        @(negedge clk);
        HaltReq = 1'b1;
        ValidE1 = 1'b1;
        step_state("s6_state_halt", 2'b11);
        @(negedge clk);
        idle();
        #1;
        chk("s6_halt_en", {en1, en2}, 16'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have the port StallReq, input, 1 bit: hazard-unit request to freeze fetch/decode.
REQ-004 The module SHALL have the port HaltReq, input, 1 bit: halt instruction (ecall) executing in lane 1.
REQ-005 The module SHALL have the port ValidE1 / ValidE2, input, 1 bit each: lane 1 / lane 2 execute-stage instruction valid; lane 1 is older.
REQ-006 The module SHALL have the port PCSrcE1 / PCSrcE2, input, 2 bits each, with encoding 00 = sequential, 01 = PCTarget, 10 = ALUResult (jalr); 11 is reserved and treated as 00.
REQ-007 The module SHALL have the port SingleIssue, input, 1 bit: when 1, lane 2 fetch is disabled.
REQ-008 The module SHALL have the ports en1 and en2, output, 1 bit each: PC-enables to the fetch stage.
REQ-009 The module SHALL have the ports PCSrcF1 and PCSrcF2, output, 2 bits each: gated redirect selects to the fetch stage.
REQ-010 The module SHALL have the ports FlushD and FlushE, output, 1 bit each: squash the decode and execute pipeline registers.
REQ-011 The module SHALL have the port KillE2, output, 1 bit: squash lane 2 in execute, because it is younger than a lane-1 redirect or halt.
REQ-012 The module SHALL have the port State, output, 2 bits: current FSM state.
REQ-013 The module SHALL have the ports StallCnt and RedirCnt, output, 16 bits each: saturating performance counters.

Function
REQ-014 The FSM SHALL have the states RUN=00, STALL=01, REDIR=10 and HALT=11.
REQ-015 Each cycle in RUN or STALL, the events SHALL be resolved in this priority order: halt, then lane-1 redirect, then lane-2 redirect, then stall, then run.
REQ-016 A halt SHALL be the condition HaltReq & ValidE1; it drives en1=en2=0, KillE2=1, FlushD=1 and PCSrcF1=PCSrcF2=00, and the next state is HALT.
REQ-017 A lane-1 redirect SHALL be the condition ValidE1 & PCSrcE1 in {01,10}; it drives PCSrcF1=PCSrcE1, PCSrcF2=00, KillE2=1, FlushD=FlushE=1 and en1=en2=1, and the next state is REDIR.
REQ-018 A lane-2 redirect SHALL be the condition ValidE2 & PCSrcE2 in {01,10} & no lane-1 redirect; it drives PCSrcF2=PCSrcE2, PCSrcF1=00, FlushD=FlushE=1 and KillE2=0, and the next state is REDIR.
REQ-019 A redirect SHALL override StallReq in the same cycle, and that cycle SHALL NOT count as a stall.
REQ-020 A stall (StallReq with no redirect and no halt) SHALL drive en1=en2=0 with no flush, and the next state is STALL; the FSM SHALL stay in STALL while StallReq=1 and return to RUN the first cycle StallReq=0.
REQ-021 In REDIR, the block SHALL drive FlushD=1, PCSrcF=00 and en=1, ignore StallReq and both PCSrcE inputs, and unconditionally return to RUN, so that a redirect costs exactly 2 bubble cycles.
REQ-022 HALT SHALL be sticky: en1=en2=0, all other outputs 0, and all inputs ignored until reset.
REQ-023 en2 SHALL be forced to 0 whenever SingleIssue=1, regardless of state.
REQ-024 All flush, kill, enable and PCSrcF outputs SHALL be combinational from the state and the current inputs, with zero latency.
REQ-025 StallCnt SHALL increment by 1 for each cycle in which a stall is taken, and saturate at 0xFFFF.
REQ-026 RedirCnt SHALL increment by 1 for each redirect taken, and saturate at 0xFFFF.
REQ-027 Reserved PCSrc value 11 SHALL never trigger a redirect.

Reset
REQ-028 When rst=0, the block SHALL immediately set State=RUN and StallCnt=RedirCnt=0, independent of clk.
REQ-029 While in reset, the outputs SHALL be en1=1, en2=~SingleIssue, FlushD=FlushE=KillE2=0 and PCSrcF1=PCSrcF2=00.
REQ-030 A reset asserted mid-STALL, mid-REDIR or in HALT SHALL abandon the operation, and the block SHALL resume in RUN on the first edge after rst returns to 1.

Structure
REQ-031 A shared package fetch_pkg SHALL hold the FSM state enum, the PCSrc encoding constants, and the counter width constant (16).
REQ-032 One sub-module, sat_counter (parameterised width, with increment enable and asynchronous active-low reset), SHALL be instantiated twice, once for StallCnt and once for RedirCnt.

Verification
REQ-033 Scenario 1: release reset with no events for 5 cycles -> State=RUN, en1=en2=1, no flushes, both counters 0.
REQ-034 Scenario 2: StallReq=1 for 3 cycles -> en1=en2=0 for those 3 cycles, State=STALL, StallCnt=3; RUN on the 4th cycle.
REQ-035 Scenario 3: ValidE1=ValidE2=1, PCSrcE1=01, PCSrcE2=10 -> PCSrcF1=01, PCSrcF2=00, KillE2=1, FlushD=FlushE=1; next cycle REDIR with FlushD=1; RedirCnt=1.
REQ-036 Scenario 4: StallReq=1 together with lane-2 PCSrcE2=10 -> redirect taken, PCSrcF2=10, en=1, StallCnt unchanged.
REQ-037 Scenario 5: HaltReq=ValidE1=1 together with PCSrcE2=01 -> HALT, KillE2=1, en=0 for 10 cycles despite StallReq toggling; rst pulse -> RUN.
REQ-038 Scenario 6: preload RedirCnt to 0xFFFE, then issue 3 redirects -> RedirCnt=0xFFFF; with SingleIssue=1, en2=0 in every state.
